ifetch_unit: RTL

- Instruction-fetch stage directly downstream of the PC update logic.
- Takes the next PC value as a redirect and walks sequential addresses from it.
- Issues valid/ready requests to instruction memory and buffers the returned words with their PCs in a small FIFO for decode.
- Handles flushes caused by taken branches: stale in-flight responses are discarded and the FIFO is cleared.

---
 rtl/ifetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential instruction fetch with one outstanding imem request and a prefetch FIFO.
// Optional misaligned-redirect trap entry enabled by IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
`ifdef IFETCH_MISALIGN_TRAP_EN
  output logic        inst_misaligned,
`endif
  input  logic        inst_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {RUN, WAIT, DISCARD} state_t;
  state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] mem_pc_q [DEPTH];
  logic [31:0] mem_pc_d [DEPTH];
  logic [31:0] mem_data_q [DEPTH];
  logic [31:0] mem_data_d [DEPTH];
  logic [31:0] last_pc_q, last_pc_d, last_data_q, last_data_d;
  logic trap_q, trap_d, trap_pend_q, trap_pend_d;
  logic accept, pop, push, trap_push, wr_en, misaligned;
  logic [31:0] push_pc, push_data, load_pc;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign misaligned = redirect_pc[1:0] != 2'b00;
  assign load_pc    = redirect_pc;
`else
  assign misaligned = 1'b0;
  assign load_pc    = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign imem_req_addr  = fetch_pc_q;
  assign imem_req_valid = !reset && !trap_q && state_q == RUN && count_q < CW'(DEPTH);
  assign inst_valid     = count_q != '0;
  assign inst_pc        = inst_valid ? mem_pc_q[rd_ptr_q] : last_pc_q;
  assign inst_data      = inst_valid ? mem_data_q[rd_ptr_q] : last_data_q;

  always_comb begin
    accept      = imem_req_valid && imem_req_ready;
    pop         = inst_valid && inst_ready;
    trap_push   = trap_pend_q && state_q == RUN && count_q == '0;
    push        = (state_q == WAIT && imem_resp_valid) || trap_push;
    wr_en       = !redirect_valid && push && (count_q < CW'(DEPTH) || pop);
    push_pc     = trap_push ? fetch_pc_q : req_pc_q;
    push_data   = trap_push ? 32'h0000_0013 : imem_resp_data;
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_pc_d    = mem_pc_q;
    mem_data_d  = mem_data_q;
    trap_d      = trap_q;
    trap_pend_d = trap_pend_q && !trap_push;
    last_pc_d   = inst_pc;
    last_data_d = inst_data;
    if (accept) begin
      state_d    = WAIT;
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (state_q != RUN && imem_resp_valid) state_d = RUN;
    if (wr_en) begin
      mem_pc_d[wr_ptr_q]   = push_pc;
      mem_data_d[wr_ptr_q] = push_data;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(wr_en) - CW'(pop);
    // Redirect wins: flush, reload, and remember whether a response is still owed.
    if (redirect_valid) begin
      state_d     = ((state_q != RUN && !imem_resp_valid) || accept) ? DISCARD : RUN;
      fetch_pc_d  = load_pc;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      trap_d      = misaligned;
      trap_pend_d = misaligned;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_pc_q    <= '{default: '0};
      mem_data_q  <= '{default: '0};
      last_pc_q   <= '0;
      last_data_q <= '0;
      trap_q      <= 1'b0;
      trap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_pc_q    <= mem_pc_d;
      mem_data_q  <= mem_data_d;
      last_pc_q   <= last_pc_d;
      last_data_q <= last_data_d;
      trap_q      <= trap_d;
      trap_pend_q <= trap_pend_d;
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic mem_mis_q [DEPTH];
  logic mem_mis_d [DEPTH];
  logic last_mis_q, last_mis_d;
  assign inst_misaligned = inst_valid ? mem_mis_q[rd_ptr_q] : last_mis_q;

  always_comb begin
    mem_mis_d  = mem_mis_q;
    last_mis_d = inst_misaligned;
    if (wr_en) mem_mis_d[wr_ptr_q] = trap_push;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_mis_q  <= '{default: 1'b0};
      last_mis_q <= 1'b0;
    end else begin
      mem_mis_q  <= mem_mis_d;
      last_mis_q <= last_mis_d;
    end
  end
`endif
endmodule
